counter_monitor: RTL and testbench

COUNTER_MONITOR -- requirements
Module: counter_monitor

---
 rtl/counter_pkg.sv | 29 ++
 rtl/step_classifier.sv | 29 ++
 rtl/counter_monitor.sv | 87 ++++++++
 tb/tb_counter_monitor.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared constants and types for the up/down counter and its monitor.
// The monitor does all of its arithmetic at 11-bit signed width.
package counter_pkg;

    localparam int CNT_W = 10;
    localparam int EXT_W = 11;

    localparam logic signed [EXT_W-1:0] MIN     = -11'sd263;
    localparam logic signed [EXT_W-1:0] MAX     =  11'sd269;
    localparam logic signed [EXT_W-1:0] INV     = -11'sd47;
    localparam logic signed [EXT_W-1:0] INIT    =  11'sd17;
    localparam logic signed [EXT_W-1:0] UP_STEP =  11'sd4;
    localparam logic signed [EXT_W-1:0] DN_STEP =  11'sd10;

    localparam logic [7:0] ERR_SAT = 8'hFF;

    typedef enum logic [1:0] {
        DIR_UNKNOWN = 2'd0,
        DIR_UP      = 2'd1,
        DIR_DOWN    = 2'd2,
        DIR_HOLD    = 2'd3
    } dir_t;

    typedef enum logic {
        WAIT_INIT = 1'b0,
        TRACK     = 1'b1
    } mon_state_t;

endpackage

// File: rtl/step_classifier.sv
// Combinational classification of one counter transition p -> c.
// The range check and the step checks are independent; the caller combines them.
module step_classifier
    import counter_pkg::*;
(
    input  logic signed [EXT_W-1:0] p,
    input  logic signed [EXT_W-1:0] c,
    output logic                    up_ok,
    output logic                    dn_ok,
    output logic                    hold_hi,
    output logic                    hold_lo,
    output logic                    range_err
);

    logic w_same;
    assign w_same = (c == p);

    assign range_err = (c > MAX) || (c < MIN) || (c == INV);

    // The counter jumps over INV, so the step that would land on it moves two steps at once.
    assign up_ok = ((c == p + UP_STEP) && (c != INV)) ||
                   ((p == INV - UP_STEP) && (c == INV + UP_STEP));
    assign dn_ok = ((c == p - DN_STEP) && (c != INV)) ||
                   ((p == INV + DN_STEP) && (c == INV - DN_STEP));

    assign hold_hi = (p > MAX - UP_STEP) && w_same;
    assign hold_lo = (p < MIN + DN_STEP) && w_same;

endmodule

// File: rtl/counter_monitor.sv
// Watches the sampled count of an up/down counter, recovers its direction
// and flags illegal samples; all outputs are registered one cycle after the sample.
module counter_monitor
    import counter_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [CNT_W-1:0] cnt,
    output logic [1:0]              dir,
    output logic                    err,
    output logic [7:0]              err_cnt,
    output logic signed [EXT_W-1:0] step,
    output logic                    sat_hi,
    output logic                    sat_lo
);

    mon_state_t              r_state;
    logic signed [EXT_W-1:0] r_prev;

    logic signed [EXT_W-1:0] w_c;
    logic signed [EXT_W-1:0] w_step;
    logic w_up_ok, w_dn_ok, w_hold_hi, w_hold_lo, w_range_err;
    logic w_legal;
    logic [7:0] w_err_cnt_inc;

    assign w_c    = {cnt[CNT_W-1], cnt};
    assign w_step = w_c - r_prev;

    step_classifier u_cls (
        .p         (r_prev),
        .c         (w_c),
        .up_ok     (w_up_ok),
        .dn_ok     (w_dn_ok),
        .hold_hi   (w_hold_hi),
        .hold_lo   (w_hold_lo),
        .range_err (w_range_err)
    );

    assign w_legal       = (w_up_ok || w_dn_ok || w_hold_hi || w_hold_lo) && !w_range_err;
    assign w_err_cnt_inc = (err_cnt == ERR_SAT) ? err_cnt : err_cnt + 8'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= WAIT_INIT;
            r_prev  <= INIT;
            dir     <= DIR_UNKNOWN;
            err     <= 1'b0;
            err_cnt <= 8'd0;
            step    <= '0;
            sat_hi  <= 1'b0;
            sat_lo  <= 1'b0;
        end else begin
            r_prev <= w_c;
            step   <= w_step;
            case (r_state)
                WAIT_INIT: begin
                    // Even a wrong first sample becomes the reference for tracking.
                    r_state <= TRACK;
                    dir     <= DIR_UNKNOWN;
                    sat_hi  <= 1'b0;
                    sat_lo  <= 1'b0;
                    if (w_c != INIT) begin
                        err     <= 1'b1;
                        err_cnt <= w_err_cnt_inc;
                    end
                end
                default: begin
                    r_state <= TRACK;
                    if (w_legal) begin
                        if (w_hold_hi || w_hold_lo) dir <= DIR_HOLD;
                        else if (w_up_ok)           dir <= DIR_UP;
                        else                        dir <= DIR_DOWN;
                        sat_hi <= w_hold_hi;
                        sat_lo <= w_hold_lo;
                    end else begin
                        dir     <= DIR_UNKNOWN;
                        sat_hi  <= 1'b0;
                        sat_lo  <= 1'b0;
                        err     <= 1'b1;
                        err_cnt <= w_err_cnt_inc;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_monitor.sv
// Directed bench for counter_monitor: a sample-level reference model checked every
// cycle, plus literal expectations at the interesting points of each scenario.
module tb_counter_monitor;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic signed [9:0]  cnt = 10'sd17;
    logic [1:0]         dir;
    logic               err;
    logic [7:0]         err_cnt;
    logic signed [10:0] step;
    logic               sat_hi;
    logic               sat_lo;

    int n_pass  = 0;
    int n_total = 0;

    counter_monitor dut (
        .clk     (clk),
        .rst     (rst),
        .cnt     (cnt),
        .dir     (dir),
        .err     (err),
        .err_cnt (err_cnt),
        .step    (step),
        .sat_hi  (sat_hi),
        .sat_lo  (sat_lo)
    );

    always #5 clk = ~clk;

    // Reference model: one sample judged by the counter's rules in plain integers.
    typedef struct {
        int dir;
        bit bad;
        bit shi;
        bit slo;
    } pred_t;

    function automatic pred_t predict(int p, int c, bit first);
        pred_t r;
        bit rng, up, dn, hh, hl, legal;
        r.dir = 0; r.bad = 0; r.shi = 0; r.slo = 0;
        if (first) begin
            r.bad = (c != 17);
        end else begin
            rng   = (c > 269) || (c < -263) || (c == -47);
            up    = ((c == p + 4) && (c != -47)) || (p == -51 && c == -43);
            dn    = ((c == p - 10) && (c != -47)) || (p == -37 && c == -57);
            hh    = (c == p) && (p > 265);
            hl    = (c == p) && (p < -253);
            legal = (up || dn || hh || hl) && !rng;
            r.bad = !legal;
            if (legal) begin
                r.dir = (hh || hl) ? 3 : (up ? 1 : 2);
                r.shi = hh;
                r.slo = hl;
            end
        end
        return r;
    endfunction

    bit    m_first = 1;
    int    m_prev  = 17;
    int    m_dir = 0, m_ecnt = 0, m_step = 0;
    bit    m_err = 0, m_shi = 0, m_slo = 0;
    pred_t m_nxt;

    always @* m_nxt = predict(m_prev, int'(cnt), m_first);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_first <= 1; m_prev <= 17; m_dir <= 0; m_err <= 0;
            m_ecnt  <= 0; m_step <= 0;  m_shi <= 0; m_slo <= 0;
        end else begin
            m_first <= 0;
            m_prev  <= int'(cnt);
            m_step  <= int'(cnt) - m_prev;
            m_dir   <= m_nxt.dir;
            m_shi   <= m_nxt.shi;
            m_slo   <= m_nxt.slo;
            if (m_nxt.bad) begin
                m_err  <= 1;
                m_ecnt <= (m_ecnt < 255) ? m_ecnt + 1 : 255;
            end
        end
    end

    always @(negedge clk) begin
        n_total++;
        if (int'(dir) == m_dir && err == m_err && int'(err_cnt) == m_ecnt &&
            int'(step) == m_step && sat_hi == m_shi && sat_lo == m_slo)
            n_pass++;
        else
            $display("FAIL model t=%0t got dir=%0d err=%0d cnt=%0d step=%0d hi=%0d lo=%0d exp dir=%0d err=%0d cnt=%0d step=%0d hi=%0d lo=%0d",
                     $time, dir, err, err_cnt, step, sat_hi, sat_lo,
                     m_dir, m_err, m_ecnt, m_step, m_shi, m_slo);
    end

    task automatic chk(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got %0d exp %0d", name, got, exp);
    endtask

    task automatic chk_out(input string name, input int e_dir, input int e_step,
                           input int e_err, input int e_ecnt);
        chk({name, ".dir"},     int'(dir),     e_dir);
        chk({name, ".step"},    int'(step),    e_step);
        chk({name, ".err"},     int'(err),     e_err);
        chk({name, ".err_cnt"}, int'(err_cnt), e_ecnt);
    endtask

    // Called at a falling edge; returns at the falling edge after the sample was taken.
    task automatic feed(input int v);
        cnt = 10'(v);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    int seq_dn[]  = '{7, -3, -13, -23, -33, -43, -53, -49, -45, -41, -37, -57};
    int seq_up[]  = '{-67, -63, -59, -55, -51, -43};

    initial begin
        #1 rst = 1'b1;
        @(negedge clk);
        chk_out("reset", 0, 0, 0, 0);
        chk("reset.sat_hi", int'(sat_hi), 0);
        chk("reset.sat_lo", int'(sat_lo), 0);
        @(negedge clk);
        rst = 1'b0;

        // Plain up counting
        feed(17); chk_out("init17", 0, 0, 0, 0);
        feed(21); chk_out("up21",   1, 4, 0, 0);
        feed(25); chk_out("up25",   1, 4, 0, 0);

        // Down through the skip over -47, then back up through it
        do_reset();
        feed(17);
        foreach (seq_dn[i]) feed(seq_dn[i]);
        chk_out("skip_dn", 2, -20, 0, 0);
        foreach (seq_up[i]) feed(seq_up[i]);
        chk_out("skip_up", 1, 8, 0, 0);

        // Top saturation
        do_reset();
        feed(17);
        for (int k = 1; k <= 63; k++) feed(17 + 4 * k);
        chk_out("reach269", 1, 4, 0, 0);
        for (int k = 0; k < 3; k++) feed(269);
        chk_out("hold269", 3, 0, 0, 0);
        chk("hold269.sat_hi", int'(sat_hi), 1);
        feed(259);
        chk_out("leave_top", 2, -10, 0, 0);
        chk("leave_top.sat_hi", int'(sat_hi), 0);

        // Bottom saturation, legally reached
        do_reset();
        feed(17);
        for (int k = 1; k <= 28; k++) feed(17 - 10 * k);
        for (int k = 0; k < 3; k++) feed(-263);
        chk_out("hold_m263", 3, 0, 0, 0);
        chk("hold_m263.sat_lo", int'(sat_lo), 1);

        // Bottom hold at -260 after a bad first sample
        do_reset();
        feed(-260); chk_out("first_m260", 0, -277, 1, 1);
        for (int k = 0; k < 3; k++) feed(-260);
        chk_out("hold_m260", 3, 0, 1, 1);
        chk("hold_m260.sat_lo", int'(sat_lo), 1);

        // Bad step, sticky error, range faults, saturation of err_cnt
        do_reset();
        feed(17);
        feed(20);  chk_out("bad20",  0, 3, 1, 1);
        feed(24);  chk_out("up24",   1, 4, 1, 1);
        feed(24);  chk_out("same24", 0, 0, 1, 2);
        feed(-47); chk_out("inv",    0, -71, 1, 3);
        feed(300); chk_out("over",   0, 347, 1, 4);
        for (int k = 0; k < 300; k++) feed(300);
        chk_out("sat255", 0, 0, 1, 255);

        // Asynchronous reset mid-tracking
        do_reset();
        feed(17);
        feed(21);
        feed(20);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk_out("async_rst", 0, 0, 0, 0);
        chk("async_rst.sat_hi", int'(sat_hi), 0);
        @(negedge clk);
        rst = 1'b0;
        feed(5); chk_out("first5", 0, -12, 1, 1);
        feed(9); chk_out("after5", 1, 4, 1, 1);

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
